// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the router datapath stages (register stage, FSM
//   and FIFO). Holds the default storage geometry, the position of the
//   payload-length field inside a header byte, and the helper that turns a
//   header byte into the number of bytes still to come in that packet.
package router_pkg;

  // Default FIFO geometry.
  localparam int FIFO_DEPTH = 16;
  localparam int DATA_WIDTH = 8;

  // Payload length field inside a header byte.
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  // Packet counter is one bit wider than the length field so that
  // "length + parity byte" never overflows.
  localparam int CNT_W = LEN_W + 1;

  // Number of bytes that follow a header: payload length plus the parity byte.
  function automatic logic [CNT_W-1:0] hdr_len(input logic [LEN_W-1:0] len);
    return {1'b0, len} + CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// router_fifo_if
//   Handshake/data bundle between the router register stage (master side)
//   and a destination FIFO (slave side).
//   master drives : soft_reset, write_enb, lfd_state, data_in, read_enb
//   slave drives  : data_out, full, empty, rd_last
import router_pkg::*;

interface router_fifo_if #(
  parameter int WIDTH = DATA_WIDTH
);
  logic             soft_reset;
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             rd_last;

  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
    input  data_out, full, empty, rd_last
  );

  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
    output data_out, full, empty, rd_last
  );
endinterface

// File: rtl/router_fifo.sv
// router_fifo
//   Per-destination packet FIFO of the router. Each entry stores a byte plus
//   a header flag captured from lfd_state. Reads present the byte on data_out
//   one cycle after read_enb; a packet counter loaded from the header length
//   field produces rd_last alongside the packet's final (parity) byte.
//
// Ports
//   clock    : single rising-edge clock
//   reset    : asynchronous active-high reset
//   bus      : router_fifo_if.slave
//              soft_reset (sync flush), write_enb, lfd_state, data_in,
//              read_enb, data_out (registered), full, empty, rd_last
import router_pkg::*;

module router_fifo #(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  router_fifo_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // Storage: {hdr_flag, byte}. Not reset; only written entries are ever read.
  logic [WIDTH:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_last_q, rd_last_d;

  logic             full_s;
  logic             empty_s;
  logic             do_wr_s;
  logic             do_rd_s;
  logic [WIDTH:0]   rd_entry_s;

  // Same low bits with differing wrap bit means the writer is a lap ahead.
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);

  // A flush cycle swallows any concurrent request.
  assign do_wr_s = bus.write_enb && !full_s  && !bus.soft_reset;
  assign do_rd_s = bus.read_enb  && !empty_s && !bus.soft_reset;

  assign rd_entry_s = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state logic for pointers, packet counter and read outputs.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_out_d = data_out_q;
    rd_last_d  = 1'b0;

    if (bus.soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pkt_cnt_d  = '0;
      data_out_d = '0;
      rd_last_d  = 1'b0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (do_rd_s) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        data_out_d = rd_entry_s[WIDTH-1:0];
        if (rd_entry_s[WIDTH]) begin
          // Header: arm the counter with payload length plus parity byte.
          pkt_cnt_d = hdr_len(rd_entry_s[LEN_MSB:LEN_LSB]);
        end else if (pkt_cnt_q != CNT_W'(0)) begin
          pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
          rd_last_d = (pkt_cnt_q == CNT_W'(1));
        end else begin
          // Stray byte outside a packet: pass it through, no rd_last.
          pkt_cnt_d = pkt_cnt_q;
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      data_out_q <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_out_q <= data_out_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clock) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.full     = full_s;
  assign bus.empty    = empty_s;

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;
  import router_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of {hdr, byte} entries plus packet bookkeeping.
  logic [8:0] mq[$];
  logic [7:0] m_dout;
  logic       m_last;
  int         m_cnt;

  task automatic model_reset();
    mq.delete();
    m_dout = 8'h00;
    m_last = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic we, input logic lfd, input logic [7:0] din,
                            input logic re, input logic sr);
    bit was_full;
    bit was_empty;
    logic [8:0] e;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (sr) begin
      model_reset();
    end else begin
      m_last = 1'b0;
      if (re && !was_empty) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) begin
          m_last = (m_cnt == 1);
          m_cnt  = m_cnt - 1;
        end
      end
      if (we && !was_full) mq.push_back({lfd, din});
    end
  endtask

  task automatic tick(input logic we, input logic lfd, input logic [7:0] din,
                      input logic re, input logic sr);
    bus.write_enb  = we;
    bus.lfd_state  = lfd;
    bus.data_in    = din;
    bus.read_enb   = re;
    bus.soft_reset = sr;
    @(posedge clk);
    model_step(we, lfd, din, re, sr);
    #1;
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.soft_reset = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", bus.data_out); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    n_tests++; if (bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", bus.rd_last); end
    do_reset();
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5];
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h3F};
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, (i == 0), pkt[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (bus.data_out !== pkt[i]) begin n_fail++; $display("FAIL pkt_dout[%0d] got=%h exp=%h", i, bus.data_out, pkt[i]); end
      n_tests++; if (bus.rd_last !== (i == 4)) begin n_fail++; $display("FAIL pkt_last[%0d] got=%b exp=%b", i, bus.rd_last, (i == 4)); end
    end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL pkt_empty got=%b exp=1", bus.empty); end
    tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_tests++; if (bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL pkt_last_pulse got=%b exp=0", bus.rd_last); end
  endtask

  task automatic test_full();
    logic [7:0] vals [DEPTH];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      vals[i] = 8'($urandom_range(0, 255));
      n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL full_early[%0d] got=%b exp=0", i, bus.full); end
      tick(1'b1, 1'b0, vals[i], 1'b0, 1'b0);
    end
    n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_set got=%b exp=1", bus.full); end
    tick(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop got=%b exp=1", bus.full); end
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (bus.data_out !== vals[i]) begin n_fail++; $display("FAIL full_order[%0d] got=%h exp=%h", i, bus.data_out, vals[i]); end
      n_tests++; if (bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL full_last[%0d] got=%b exp=0", i, bus.rd_last); end
    end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL full_drained got=%b exp=1", bus.empty); end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== vals[DEPTH-1]) begin n_fail++; $display("FAIL empty_read_hold got=%h exp=%h", bus.data_out, vals[DEPTH-1]); end
  endtask

  task automatic test_full_rw();
    logic [7:0] vals [DEPTH];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      vals[i] = 8'(i * 7 + 3);
      tick(1'b1, 1'b0, vals[i], 1'b0, 1'b0);
    end
    tick(1'b1, 1'b0, 8'hCC, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== vals[0]) begin n_fail++; $display("FAIL fullrw_dout got=%h exp=%h", bus.data_out, vals[0]); end
    n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL fullrw_full got=%b exp=0", bus.full); end
    for (int i = 1; i < DEPTH; i++) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (bus.data_out !== vals[i]) begin n_fail++; $display("FAIL fullrw_order[%0d] got=%h exp=%h", i, bus.data_out, vals[i]); end
    end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fullrw_dropped got_empty=%b exp=1", bus.empty); end
  endtask

  task automatic test_empty_rw();
    do_reset();
    tick(1'b1, 1'b0, 8'hA5, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL emptyrw_dout got=%h exp=00", bus.data_out); end
    n_tests++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL emptyrw_empty got=%b exp=0", bus.empty); end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL emptyrw_read got=%h exp=a5", bus.data_out); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL emptyrw_empty2 got=%b exp=1", bus.empty); end
  endtask

  task automatic test_soft_reset();
    do_reset();
    tick(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 8'h99, 1'b1, 1'b1);
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL srst_empty got=%b exp=1", bus.empty); end
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL srst_dout got=%h exp=00", bus.data_out); end
    n_tests++; if (dut.pkt_cnt_q !== 7'd0) begin n_fail++; $display("FAIL srst_cnt got=%0d exp=0", dut.pkt_cnt_q); end
    n_tests++; if (bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL srst_last got=%b exp=0", bus.rd_last); end
    tick(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'h01 || bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL srst_hdr got=%h/%b exp=01/0", bus.data_out, bus.rd_last); end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'h55 || bus.rd_last !== 1'b1) begin n_fail++; $display("FAIL srst_par got=%h/%b exp=55/1", bus.data_out, bus.rd_last); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL srst_end_empty got=%b exp=1", bus.empty); end
  endtask

  task automatic test_zero_len();
    do_reset();
    tick(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h9A, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL zl_hdr_last got=%b exp=0", bus.rd_last); end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'h9A || bus.rd_last !== 1'b1) begin n_fail++; $display("FAIL zl_par got=%h/%b exp=9a/1", bus.data_out, bus.rd_last); end
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'h77 || bus.rd_last !== 1'b0) begin n_fail++; $display("FAIL zl_stray got=%h/%b exp=77/0", bus.data_out, bus.rd_last); end
    n_tests++; if (dut.pkt_cnt_q !== 7'd0) begin n_fail++; $display("FAIL zl_cnt got=%0d exp=0", dut.pkt_cnt_q); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (bus.data_out !== 8'h11) begin n_fail++; $display("FAIL ar_pre got=%h exp=11", bus.data_out); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL ar_dout got=%h exp=00", bus.data_out); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty got=%b exp=1", bus.empty); end
    do_reset();
  endtask

  task automatic test_random();
    logic we, lfd, re, sr;
    logic [7:0] din;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      we  = ($urandom_range(0, 99) < 55);
      re  = ($urandom_range(0, 99) < 50);
      lfd = ($urandom_range(0, 7) == 0);
      sr  = ($urandom_range(0, 63) == 0);
      din = 8'($urandom_range(0, 255));
      if (lfd) din[7:2] = 6'($urandom_range(0, 5));
      tick(we, lfd, din, re, sr);
      n_tests++; if (bus.data_out !== m_dout) begin n_fail++; $display("FAIL rnd_dout c=%0d got=%h exp=%h", c, bus.data_out, m_dout); end
      n_tests++; if (bus.rd_last !== m_last) begin n_fail++; $display("FAIL rnd_last c=%0d got=%b exp=%b", c, bus.rd_last, m_last); end
      n_tests++; if (bus.full !== (mq.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, bus.full, (mq.size() == DEPTH)); end
      n_tests++; if (bus.empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty c=%0d got=%b exp=%b", c, bus.empty, (mq.size() == 0)); end
      n_tests++; if (int'(dut.pkt_cnt_q) !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, dut.pkt_cnt_q, m_cnt); end
    end
  endtask

  initial begin
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    bus.read_enb   = 1'b0;
    bus.soft_reset = 1'b0;
    model_reset();
    test_reset();
    test_packet();
    test_full();
    test_full_rw();
    test_empty_rw();
    test_soft_reset();
    test_zero_len();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
